// File: rtl/mv_seq_pkg.sv
// Shared types and helpers for the MV chunk sequencer.
package mv_seq_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mv_seq_state_t;

    // Bit positions in the per-cycle error-cause vector (sticky error is their OR).
    localparam int unsigned ERR_CHUNK_OUT = 0;  // capture strobe outside RUN or buffer full
    localparam int unsigned ERR_CHUNK_REQ = 1;  // chunk advance / pointer reset outside RUN
    localparam int unsigned ERR_VEC_VALID = 2;  // vector-done with short capture count
    localparam int unsigned ERR_NUM       = 3;

    function automatic int unsigned chunk_count(input int unsigned in_len,
                                                input int unsigned regs);
        return in_len / regs;
    endfunction

endpackage

// File: rtl/mv_chunk_buffer.sv
// Byte-write, chunk-read register file; a chunk is LANES consecutive bytes.
module mv_chunk_buffer #(
    parameter int unsigned DEPTH_BYTES = 16,
    parameter int unsigned LANES       = 4,
    localparam int unsigned ADDR_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1,
    localparam int unsigned NCH        = DEPTH_BYTES / LANES,
    localparam int unsigned CADDR_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [CADDR_W-1:0]   rd_chunk_addr,
    output logic [LANES*8-1:0]   rd_chunk
);

    logic [7:0] mem [DEPTH_BYTES];

    // Byte storage, cleared to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational chunk read; lane k holds byte rd_chunk_addr*LANES+k.
    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_chunk = '0;
        a        = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            a = ADDR_W'(32'(rd_chunk_addr) * LANES + 32'(k));
            rd_chunk[k*8 +: 8] = mem[a];
        end
    end

endmodule

// File: rtl/mv_chunk_sequencer.sv
// Sequencer for one chunked MV datapath: buffers the input vector, serves chunks,
// captures output elements and streams them out.
// Optional build macro MV_SEQ_PERF_CNT_EN adds run_cycles / vec_count counters.
module mv_chunk_sequencer
    import mv_seq_pkg::*;
#(
    parameter int unsigned IN_VEC_LEN   = 16,
    parameter int unsigned OUT_VEC_LEN  = 8,
    parameter int unsigned WORKING_REGS = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [7:0]                s_data,
    output logic                      mv_in_data_ready,
    output logic [WORKING_REGS*8-1:0] mv_in_data,
    input  logic                      mv_req_chunk_in,
    input  logic                      mv_req_chunk_ptr_rst,
    input  logic                      mv_req_chunk_out,
    input  logic [7:0]                mv_write_out_data,
    input  logic                      mv_out_vector_valid,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [7:0]                m_data,
    output logic                      busy,
    output logic                      error
`ifdef MV_SEQ_PERF_CNT_EN
   ,output logic [31:0]               run_cycles,
    output logic [15:0]               vec_count
`endif
);

    localparam int unsigned NCHUNK = chunk_count(IN_VEC_LEN, WORKING_REGS);
    localparam int unsigned WR_W   = $clog2(IN_VEC_LEN + 1);
    localparam int unsigned AW     = (IN_VEC_LEN > 1) ? $clog2(IN_VEC_LEN) : 1;
    localparam int unsigned CP_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned OI_W   = $clog2(OUT_VEC_LEN + 1);
    localparam int unsigned OB_W   = (OUT_VEC_LEN > 1) ? $clog2(OUT_VEC_LEN) : 1;

    mv_seq_state_t      state_q, state_d;
    logic [WR_W-1:0]    wr_idx_q, wr_idx_d;
    logic [CP_W-1:0]    chunk_ptr_q, chunk_ptr_d;
    logic [OI_W-1:0]    out_idx_q, out_idx_d;
    logic [OI_W-1:0]    rd_idx_q, rd_idx_d;
    logic               rdy_q;
    logic               error_q;
    logic               buf_wr_en;
    logic               cap_en;
    logic [ERR_NUM-1:0] err_set;
    logic [7:0]         out_buf_q [OUT_VEC_LEN];

    mv_chunk_buffer #(
        .DEPTH_BYTES (IN_VEC_LEN),
        .LANES       (WORKING_REGS)
    ) u_in_buf (
        .clk           (clk_in),
        .rst_n         (rst_n_in),
        .wr_en         (buf_wr_en),
        .wr_addr       (wr_idx_q[AW-1:0]),
        .wr_data       (s_data),
        .rd_chunk_addr (chunk_ptr_q),
        .rd_chunk      (mv_in_data)
    );

    // Next-state, pointer updates and error causes.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        chunk_ptr_d = chunk_ptr_q;
        out_idx_d   = out_idx_q;
        rd_idx_d    = rd_idx_q;
        buf_wr_en   = 1'b0;
        cap_en      = 1'b0;
        err_set     = '0;

        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    buf_wr_en = 1'b1;
                    if (wr_idx_q == WR_W'(IN_VEC_LEN - 1)) begin
                        wr_idx_d    = '0;
                        chunk_ptr_d = '0;
                        out_idx_d   = '0;
                        state_d     = RUN;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (mv_req_chunk_ptr_rst) begin
                    chunk_ptr_d = '0;
                end else if (mv_req_chunk_in) begin
                    chunk_ptr_d = (chunk_ptr_q == CP_W'(NCHUNK - 1)) ? '0 : chunk_ptr_q + 1'b1;
                end
                if (mv_req_chunk_out) begin
                    if (out_idx_q == OI_W'(OUT_VEC_LEN)) begin
                        err_set[ERR_CHUNK_OUT] = 1'b1;
                    end else begin
                        cap_en    = 1'b1;
                        out_idx_d = out_idx_q + 1'b1;
                        if (out_idx_q == OI_W'(OUT_VEC_LEN - 1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                // Judged on the post-capture count so a same-cycle final strobe is legal.
                if (mv_out_vector_valid) begin
                    state_d = DRAIN;
                    if (out_idx_d != OI_W'(OUT_VEC_LEN)) begin
                        err_set[ERR_VEC_VALID] = 1'b1;
                    end
                end
                if (state_d == DRAIN) begin
                    rd_idx_d = '0;
                end
            end
            DRAIN: begin
                if (rd_idx_q == out_idx_q) begin
                    // Nothing was captured; leave without emitting.
                    rd_idx_d = '0;
                    state_d  = LOAD;
                end else if (m_ready) begin
                    if (rd_idx_q == out_idx_q - 1'b1) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        if (state_q != RUN) begin
            if (mv_req_chunk_out) err_set[ERR_CHUNK_OUT] = 1'b1;
            if (mv_req_chunk_in || mv_req_chunk_ptr_rst) err_set[ERR_CHUNK_REQ] = 1'b1;
            if (mv_out_vector_valid && (out_idx_q != OI_W'(OUT_VEC_LEN))) begin
                err_set[ERR_VEC_VALID] = 1'b1;
            end
        end
    end

    // Control state, pointers, datapath-ready flag and sticky error.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            chunk_ptr_q <= '0;
            out_idx_q   <= '0;
            rd_idx_q    <= '0;
            rdy_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            chunk_ptr_q <= chunk_ptr_d;
            out_idx_q   <= out_idx_d;
            rd_idx_q    <= rd_idx_d;
            rdy_q       <= (state_d == RUN);
            error_q     <= error_q | (|err_set);
        end
    end

    // Output element capture buffer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(OUT_VEC_LEN); i++) begin
                out_buf_q[i] <= 8'h00;
            end
        end else if (cap_en) begin
            out_buf_q[out_idx_q[OB_W-1:0]] <= mv_write_out_data;
        end
    end

    // Stream-side outputs decoded from state.
    always_comb begin
        s_ready          = (state_q == LOAD);
        mv_in_data_ready = rdy_q;
        m_valid          = (state_q == DRAIN) && (rd_idx_q != out_idx_q);
        m_data           = m_valid ? out_buf_q[rd_idx_q[OB_W-1:0]] : 8'h00;
        busy             = (state_q != LOAD) || (wr_idx_q != '0);
        error            = error_q;
    end

`ifdef MV_SEQ_PERF_CNT_EN
    logic [31:0] run_cycles_q;
    logic [15:0] vec_count_q;

    // RUN-duration counter (saturating, cleared on RUN entry) and completed-vector count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_cycles_q <= '0;
            vec_count_q  <= '0;
        end else begin
            if ((state_q != RUN) && (state_d == RUN)) begin
                run_cycles_q <= '0;
            end else if ((state_q == RUN) && (run_cycles_q != 32'hFFFF_FFFF)) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end
            if ((state_q == DRAIN) && (state_d == LOAD)) begin
                vec_count_q <= vec_count_q + 16'd1;
            end
        end
    end

    assign run_cycles = run_cycles_q;
    assign vec_count  = vec_count_q;
`endif

endmodule

// File: doc/mv_chunk_sequencer.md
Name: mv_chunk_sequencer

Overview:
- Controller that sequences one matrix-vector product unit (chunked 8-bit MV datapath, WORKING_REGS lanes per chunk).
- Accepts an input vector as a byte stream and buffers it as chunks. Serves chunks to the datapath on its chunk-request/pointer-reset strobes.
- Captures each output element on the datapath's output strobe, then streams the finished output vector downstream.
- Sits between the layer-level byte streams and the MV datapath; one instance per MV unit.

Parameters:
- IN_VEC_LEN, 16, input vector length in bytes; multiple of WORKING_REGS.
- OUT_VEC_LEN, 8, output vector length in bytes.
- WORKING_REGS, 4, lanes per chunk; must match the datapath's lane count.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte ready
- s_data  in  8  input vector byte, element order 0..IN_VEC_LEN-1
- mv_in_data_ready  out  1  full vector buffered; datapath may start
- mv_in_data  out  WORKING_REGS*8  current chunk; lane k = element ptr*WORKING_REGS+k
- mv_req_chunk_in  in  1  advance chunk pointer
- mv_req_chunk_ptr_rst  in  1  chunk pointer to 0
- mv_req_chunk_out  in  1  output element strobe
- mv_write_out_data  in  8  output element value (signed)
- mv_out_vector_valid  in  1  datapath finished vector
- m_valid  out  1  output byte valid
- m_ready  in  1  output byte ready
- m_data  out  8  output vector byte, element order 0..OUT_VEC_LEN-1
- busy  out  1  state != LOAD or any byte buffered
- error  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock clk_in; reset is asynchronous and active-low.
- Reset values: state=LOAD, all pointers 0, s_ready=1, mv_in_data_ready=0, m_valid=0, error=0, busy=0, buffers cleared to 0.
- NCHUNK = IN_VEC_LEN/WORKING_REGS.
- States LOAD -> RUN -> DRAIN -> LOAD.
- LOAD:
  - s_ready=1; each s_valid&s_ready writes byte wr_idx into the input buffer and increments wr_idx.
  - On the handshake of byte IN_VEC_LEN-1: next cycle RUN, wr_idx=0, s_ready=0, chunk_ptr=0, out_idx=0.
- RUN:
  - mv_in_data_ready=1 (registered).
  - mv_in_data is combinational from the buffer at chunk_ptr (zero registered-read latency, matching a single-cycle FIFO).
  - mv_req_chunk_ptr_rst has priority over mv_req_chunk_in and sets chunk_ptr=0.
  - Otherwise mv_req_chunk_in sets chunk_ptr = (chunk_ptr==NCHUNK-1) ? 0 : chunk_ptr+1.
  - mv_req_chunk_out writes mv_write_out_data to out_buf[out_idx] and increments out_idx.
  - Exit: a strobe when out_idx==OUT_VEC_LEN-1, or mv_out_vector_valid, moves the state to DRAIN next cycle and drops mv_in_data_ready. If both fire the same cycle, the capture happens first.
- DRAIN:
  - m_valid=1 and m_data=out_buf[rd_idx].
  - Each m_valid&m_ready increments rd_idx.
  - After the handshake of the last byte: m_valid=0, state LOAD, s_ready=1.
  - m_data holds stable while m_valid&!m_ready.
- Error conditions; each sets error, and error holds until reset:
  - mv_req_chunk_out outside RUN, or with out_idx==OUT_VEC_LEN; the write is dropped.
  - mv_req_chunk_in or mv_req_chunk_ptr_rst outside RUN; ignored.
  - mv_out_vector_valid with out_idx != OUT_VEC_LEN; DRAIN proceeds with the captured count only.
- Mid-operation reset: returns immediately to reset values; partial vectors are discarded.
- Widths: wr_idx $clog2(IN_VEC_LEN+1), chunk_ptr $clog2(NCHUNK) (minimum 1), out_idx and rd_idx $clog2(OUT_VEC_LEN+1).

Optional Feature:
- Macro MV_SEQ_PERF_CNT_EN.
- With the macro:
  - Extra output run_cycles [31:0] counts cycles spent in RUN for the current vector; it saturates at 0xFFFFFFFF and clears on entry to RUN.
  - Extra output vec_count [15:0] increments on each DRAIN->LOAD transition and wraps.
  - Both reset to 0.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package mv_seq_pkg holds:
  - state enum mv_seq_state_t {LOAD, RUN, DRAIN}
  - function chunk_count(in_len, regs)
  - ERR_* bit constants for simulation reporting
- Sub-module mv_chunk_buffer:
  - byte-write, chunk-read register file; params DEPTH_BYTES and LANES
  - ports: wr_en, wr_addr, wr_data, rd_chunk_addr, rd_chunk
  - async active-low clear

Test Plan:
- Load bytes 1..16 (IN=16, WR=4): mv_in_data_ready rises one cycle after the last byte, and mv_in_data = {4,3,2,1} (lane0=1).
- Pulse mv_req_chunk_in 3 times: chunk lanes go {5..8}, {9..12}, {13..16}. A 4th pulse wraps to {1..4}. Pulse ptr_rst and chunk_in in the same cycle: pointer goes to 0.
- Strobe mv_req_chunk_out 8 times with values -1,2,...,8: DRAIN emits FF,02,...,08 in order; holding m_ready=0 for 3 cycles keeps m_data stable; the state returns to LOAD after the 8th byte.
- Strobe mv_req_chunk_out during LOAD: error=1 and no buffer write. error stays 1 until rst_n_in is asserted.
- Assert rst_n_in low asynchronously mid-RUN (between clock edges): outputs clear before the next edge; the reload of a fresh vector works.
- With MV_SEQ_PERF_CNT_EN: run_cycles equals the measured RUN duration (e.g. 40), and vec_count=2 after two vectors.
